// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: shared types for the two-requester ALU arbiter.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHL = 2'b10,
    OP_AND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int NUM_REQ = 2;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// alu_core: combinational add/sub/shl/and datapath; sub reuses the adder.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  op_t               op_i,
  output logic [DATA_W-1:0] data_o,
  output logic              cout_o
);

  logic [DATA_W-1:0] b_mod_w;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] shl_w;
  logic [DATA_W-1:0] and_w;

  // op[0] selects subtract: invert b and inject the +1 as carry-in.
  assign b_mod_w = b_i ^ {DATA_W{op_i[0]}};
  assign sum_w   = {1'b0, a_i} + {1'b0, b_mod_w} + {{DATA_W{1'b0}}, op_i[0]};

  // Shift amount uses all of b; amounts >= DATA_W shift everything out.
  assign shl_w   = a_i << b_i;
  assign and_w   = a_i & b_i;

  assign data_o  = op_i[1] ? (op_i[0] ? and_w : shl_w) : sum_w[DATA_W-1:0];
  assign cout_o  = ~op_i[1] & sum_w[DATA_W];

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// alu_arbiter: round-robin share of one ALU between two requesters,
// IDLE -> EXEC -> RESP with a held response until the consumer accepts.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [DATA_W-1:0]  req_a0,
  input  logic [DATA_W-1:0]  req_b0,
  input  logic [1:0]         req_op0,
  input  logic [DATA_W-1:0]  req_a1,
  input  logic [DATA_W-1:0]  req_b1,
  input  logic [1:0]         req_op1,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_cout,
  output logic               resp_zero,
  output logic               busy
);

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              grant_w;
  logic              accept_w;
  logic [DATA_W-1:0] a_q, b_q;
  op_t               op_q;
  logic              id_q;
  logic [DATA_W-1:0] data_q;
  logic              cout_q, zero_q;
  logic [DATA_W-1:0] core_data_w;
  logic              core_cout_w;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .data_o (core_data_w),
    .cout_o (core_cout_w)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant_w   = 1'b0;
    accept_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // On a tie the requester that did not win last time goes next.
          grant_w            = (&req_valid) ? ~last_grant_q : req_valid[1];
          req_ready[grant_w] = 1'b1;
          accept_w           = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      id_q         <= 1'b0;
      data_q       <= '0;
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_w) begin
        a_q  <= grant_w ? req_a1 : req_a0;
        b_q  <= grant_w ? req_b1 : req_b0;
        op_q <= grant_w ? op_t'(req_op1) : op_t'(req_op0);
        id_q <= grant_w;
      end
      if (state_q == EXEC) begin
        data_q <= core_data_w;
        cout_q <= core_cout_w;
        zero_q <= (core_data_w == '0);
      end
      if (state_q == RESP && resp_ready) begin
        last_grant_q <= id_q;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_cout  = cout_q;
  assign resp_zero  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter: directed scoreboard bench for the shared-ALU arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_op0, req_op1;
  logic       resp_valid, resp_ready, resp_id, resp_cout, resp_zero, busy;
  logic [3:0] resp_data;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] sb_q[$];   // {id, cout, zero, data}

  alu_arbiter #(.DATA_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_cout(resp_cout), .resp_zero(resp_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    int         s;
    logic [3:0] d;
    logic       c;
    case (op)
      2'd0:    begin s = int'(a) + int'(b); d = s[3:0]; c = (s > 15); end
      2'd1:    begin s = int'(a) - int'(b); d = s[3:0]; c = (a >= b);  end
      2'd2:    begin s = int'(a) << b;      d = (b >= 4) ? 4'd0 : s[3:0]; c = 1'b0; end
      default: begin d = a & b; c = 1'b0; end
    endcase
    return {id, c, (d == 4'd0), d};
  endfunction

  function automatic logic [6:0] obs_resp();
    return {resp_id, resp_cout, resp_zero, resp_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; end
    else    begin req_a0 = a; req_b0 = b; req_op0 = op; end
    req_valid[id] = 1'b1;
  endtask

  // Expects inputs already driven with `id` as the winner; completes one op.
  task automatic run_op(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input int hold);
    int         n;
    logic [6:0] exp;
    #1;
    check({tag, "_grant"}, 16'(req_ready), id ? 16'h2 : 16'h1);
    sb_q.push_back(model(id, a, b, op));
    step();
    req_valid = 2'b00;
    n = 1;
    while (!resp_valid && n < 10) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 16'(n), 16'd2);
    if (hold > 0) req_valid = 2'b10;
    for (int i = 0; i < hold; i++) begin
      #1;
      check({tag, "_hold_resp"}, {8'd0, resp_valid, obs_resp()},
            {8'd0, 1'b1, (sb_q.size() > 0) ? sb_q[0] : 7'h7f});
      check({tag, "_hold_rdy_busy"}, {13'd0, req_ready, busy}, 16'h1);
      step();
    end
    resp_ready = 1'b1;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 7'h7f;
    check({tag, "_resp"}, {8'd0, resp_valid, obs_resp()}, {8'd0, 1'b1, exp});
    step();
    resp_ready = 1'b0;
    check({tag, "_idle"}, {14'd0, resp_valid, busy}, 16'h0);
    if (hold > 0) begin
      check({tag, "_next_grant"}, 16'(req_ready), 16'h2);
      req_valid = 2'b00;
      #1;
      check({tag, "_withdraw"}, 16'(req_ready), 16'h0);
      step();
      check({tag, "_withdraw_busy"}, 16'(busy), 16'h0);
    end
  endtask

  initial begin
    logic g;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0; req_a1 = '0; req_b1 = '0; req_op1 = '0;
    #12;
    check("reset_outputs", {req_ready, resp_valid, resp_id, resp_data, resp_cout, resp_zero, busy}, 16'h0);
    rst = 1'b0;
    step();

    drive(1'b0, 4'd7, 4'd9, 2'd0);   run_op("add_7_9", 1'b0, 4'd7, 4'd9, 2'd0, 0);
    drive(1'b1, 4'd3, 4'd5, 2'd1);   run_op("sub_3_5", 1'b1, 4'd3, 4'd5, 2'd1, 0);
    drive(1'b1, 4'd5, 4'd3, 2'd1);   run_op("sub_5_3", 1'b1, 4'd5, 4'd3, 2'd1, 0);
    drive(1'b1, 4'd3, 4'd2, 2'd2);   run_op("shl_3_2", 1'b1, 4'd3, 4'd2, 2'd2, 0);
    drive(1'b1, 4'd3, 4'd4, 2'd2);   run_op("shl_3_4", 1'b1, 4'd3, 4'd4, 2'd2, 0);
    drive(1'b1, 4'd12, 4'd10, 2'd3); run_op("and_12_10", 1'b1, 4'd12, 4'd10, 2'd3, 0);

    // Both requesters always valid, consumer always ready: grants alternate.
    drive(1'b0, 4'd9, 4'd8, 2'd0);
    drive(1'b1, 4'd15, 4'd6, 2'd3);
    resp_ready = 1'b1;
    g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", 16'(req_ready), g ? 16'h2 : 16'h1);
      sb_q.push_back(g ? model(1'b1, 4'd15, 4'd6, 2'd3) : model(1'b0, 4'd9, 4'd8, 2'd0));
      step();
      check("rr_exec", {14'd0, req_ready}, 16'h0);
      step();
      check("rr_resp", {8'd0, resp_valid, obs_resp()},
            {8'd0, 1'b1, (sb_q.size() > 0) ? sb_q.pop_front() : 7'h7f});
      step();
      g = ~g;
    end
    req_valid = 2'b00;
    resp_ready = 1'b0;
    step();

    drive(1'b0, 4'd6, 4'd6, 2'd1);   run_op("hold_sub", 1'b0, 4'd6, 4'd6, 2'd1, 5);

    // Reset while the op is in EXEC: discarded, tie pointer restored to req0.
    drive(1'b1, 4'd2, 4'd3, 2'd0);
    #1;
    check("rst_grant", 16'(req_ready), 16'h2);
    step();
    req_valid = 2'b00;
    check("rst_in_exec", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    check("rst_outputs", {req_ready, resp_valid, resp_id, resp_data, resp_cout, resp_zero, busy}, 16'h0);
    sb_q.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_resp", {14'd0, resp_valid, busy}, 16'h0);
    end
    drive(1'b0, 4'd1, 4'd14, 2'd0);
    drive(1'b1, 4'd4, 4'd1, 2'd2);
    run_op("tie_after_rst", 1'b0, 4'd1, 4'd14, 2'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
